led_fade_pwm: RTL and testbench

//  Downstream stage of the 4-LED chaser. Consumes its one-hot LED levels and drives the board pins.

---
 rtl/led_fade_pwm.sv | 81 ++++++++
 tb/tb_led_fade_pwm.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/led_fade_pwm.sv
// LED fade stage: holds each lit LED at full PWM duty, then fades it out
// linearly once its chaser input drops, leaving a comet trail.
module led_fade_pwm #(
  parameter int N_LEDS     = 4,
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 781250,
  parameter int DECAY_STEP = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] led_in,
  output logic [N_LEDS-1:0] pwm_out,
  output logic [N_LEDS-1:0] fading
);

  localparam int DW =
    (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS-1:0] STEP =
    PWM_BITS'(DECAY_STEP);
  localparam logic [DW-1:0] DEC_LAST =
    DW'(DECAY_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DW-1:0]       dec_cnt;
  logic                tick;
  logic [N_LEDS-1:0]   led_q;

  logic [PWM_BITS-1:0] bright     [N_LEDS];
  logic [PWM_BITS-1:0] bright_nxt [N_LEDS];
  logic [N_LEDS-1:0]   pwm_nxt;
  logic [N_LEDS-1:0]   fading_nxt;

  assign tick = (dec_cnt == DEC_LAST);

  // Input wins over decay when both apply in one cycle
  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      bright_nxt[i] = bright[i];
      priority case (1'b1)
        led_q[i]: bright_nxt[i] = MAX;
        tick: bright_nxt[i] =
          (bright[i] > STEP) ? bright[i] - STEP : '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    pwm_nxt    = '0;
    fading_nxt = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      pwm_nxt[i] = (bright[i] == MAX) |
                   (bright[i] > pwm_cnt);
      fading_nxt[i] = ~led_q[i] &
                      (bright[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      dec_cnt <= '0;
      led_q   <= '0;
      pwm_out <= '0;
      fading  <= '0;
      for (int i = 0; i < N_LEDS; i++)
        bright[i] <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      dec_cnt <= tick ? '0 : dec_cnt + 1'b1;
      led_q   <= led_in;
      pwm_out <= pwm_nxt;
      fading  <= fading_nxt;
      for (int i = 0; i < N_LEDS; i++)
        bright[i] <= bright_nxt[i];
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with a 4-bit PWM, decay tick every
// 4 cycles and step 6, so fades run 15 -> 9 -> 3 -> 0.
module tb_led_fade_pwm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] led_in;
  logic [3:0] pwm_out;
  logic [3:0] fading;

  int checks   = 0;
  int failures = 0;

  // Per-edge expectations for channel 0, edge n = index+1 after reset
  int exp_b[24] = '{0, 15, 15, 15, 15, 15, 15, 15,
                    15, 15, 15, 9, 9, 9, 9, 3,
                    3, 3, 3, 0, 0, 0, 0, 0};
  int exp_p[24] = '{0, 0, 1, 1, 1, 1, 1, 1,
                    1, 1, 1, 1, 0, 0, 0, 0,
                    1, 1, 1, 0, 0, 0, 0, 0};
  int exp_f[24] = '{0, 0, 0, 0, 0, 0, 0, 0,
                    0, 1, 1, 1, 1, 1, 1, 1,
                    1, 1, 1, 1, 0, 0, 0, 0};

  led_fade_pwm #(
    .N_LEDS    (4),
    .PWM_BITS  (4),
    .DECAY_DIV (4),
    .DECAY_STEP(6)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .led_in (led_in),
    .pwm_out(pwm_out),
    .fading (fading)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  initial begin
    int hi;
    reset  = 1'b1;
    led_in = 4'h0;

    // 1: reset with all inputs high, then release
    led_in = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t1_rst_pwm%0d", k), pwm_out, 0);
      chk($sformatf("t1_rst_fad%0d", k), fading, 0);
    end
    reset = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      step();
      chk($sformatf("t1_pwm_e%0d", n), pwm_out,
          (n >= 3) ? 4'hF : 4'h0);
      chk($sformatf("t1_fad_e%0d", n), fading, 0);
    end

    // 2: single pulse on channel 0, then fade
    led_in = 4'h0;
    do_reset(2);
    for (int n = 1; n <= 24; n++) begin
      led_in = (n <= 8) ? 4'b0001 : 4'b0000;
      step();
      chk($sformatf("t2_b_e%0d", n),
          dut.bright[0], exp_b[n-1]);
      chk($sformatf("t2_p_e%0d", n),
          pwm_out, exp_p[n-1]);
      chk($sformatf("t2_f_e%0d", n),
          fading, exp_f[n-1]);
    end

    // 3: saturated at 0, stays dark for two periods
    hi = 0;
    for (int n = 0; n < 32; n++) begin
      step();
      if (pwm_out[0]) hi++;
    end
    chk("t3_dark_cycles", hi, 0);
    chk("t3_bright0", dut.bright[0], 0);

    // 4: retrigger channel 1 on a tick cycle
    led_in = 4'h0;
    do_reset(2);
    for (int n = 1; n <= 18; n++) begin
      led_in = (n <= 8) ? 4'b0010 : 4'b0000;
      step();
    end
    chk("t4_b_e18", dut.bright[1], 3);
    led_in = 4'b0010;
    step();
    chk("t4_b_e19", dut.bright[1], 3);
    chk("t4_f_e19", fading, 4'b0010);
    step();
    chk("t4_b_e20", dut.bright[1], 15);
    chk("t4_dec_e20", dut.dec_cnt, 0);
    chk("t4_f_e20", fading, 0);
    step();
    chk("t4_p_e21", pwm_out, 4'b0010);

    // 5: reset while channels 2 and 3 are fading
    led_in = 4'h0;
    do_reset(2);
    for (int n = 1; n <= 12; n++) begin
      led_in = (n <= 8) ? 4'b1100 : 4'b0000;
      step();
    end
    chk("t5_b2_e12", dut.bright[2], 9);
    chk("t5_b3_e12", dut.bright[3], 9);
    chk("t5_p_e12", pwm_out, 4'b1100);
    chk("t5_f_e12", fading, 4'b1100);
    step();
    chk("t5_dec_e13", dut.dec_cnt, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_b2_rst", dut.bright[2], 0);
    chk("t5_b3_rst", dut.bright[3], 0);
    chk("t5_p_rst", pwm_out, 0);
    chk("t5_f_rst", fading, 0);
    chk("t5_dec_rst", dut.dec_cnt, 0);

    // 6: rotating one-hot chaser pattern
    led_in = 4'h0;
    do_reset(2);
    for (int n = 1; n <= 32; n++) begin
      led_in = 4'b0001 << ((n - 1) / 8);
      step();
      case (n)
        20: begin
          chk("t6_e20_b0", dut.bright[0], 0);
          chk("t6_e20_b1", dut.bright[1], 9);
          chk("t6_e20_b2", dut.bright[2], 15);
          chk("t6_e20_b3", dut.bright[3], 0);
          chk("t6_e20_p", pwm_out, 4'b0110);
        end
        24: begin
          chk("t6_e24_b0", dut.bright[0], 0);
          chk("t6_e24_b1", dut.bright[1], 3);
          chk("t6_e24_b2", dut.bright[2], 15);
          chk("t6_e24_b3", dut.bright[3], 0);
        end
        28: begin
          chk("t6_e28_b0", dut.bright[0], 0);
          chk("t6_e28_b1", dut.bright[1], 0);
          chk("t6_e28_b2", dut.bright[2], 9);
          chk("t6_e28_b3", dut.bright[3], 15);
        end
        30: chk("t6_e30_p", pwm_out, 4'b1000);
        32: begin
          chk("t6_e32_b2", dut.bright[2], 3);
          chk("t6_e32_b3", dut.bright[3], 15);
          chk("t6_e32_p", pwm_out, 4'b1000);
        end
        default: ;
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
